// File: rtl/bitmanip_serial_unit.sv
// Serial bit-extract (BEXT) / bit-deposit (BDEP) engine feeding the multiplier's multi-cycle result port.
// Optional early termination on exhausted mask bits is enabled with BITMANIP_EARLY_EXIT_EN.
module bitmanip_serial_unit #(
   parameter int unsigned WIDTH          = 64,
   parameter int unsigned BITS_PER_CYCLE = 4,
   parameter int unsigned TRANS_ID_W     = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic                  op_bdep_i,
   input  logic [WIDTH-1:0]      operand_a_i,
   input  logic [WIDTH-1:0]      operand_b_i,
   input  logic [TRANS_ID_W-1:0] trans_id_i,
   output logic                  multi_cycle_o,
   output logic [WIDTH-1:0]      multi_cycle_result_o,
   output logic [TRANS_ID_W-1:0] trans_id_o
);

   localparam int unsigned IDXW = $clog2(WIDTH);
   localparam int unsigned CNTW = IDXW + 1;
   localparam logic [CNTW-1:0] STEP   = CNTW'(BITS_PER_CYCLE);
   localparam logic [CNTW-1:0] LAST_J = CNTW'(WIDTH - BITS_PER_CYCLE);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]            state_q;
   logic [WIDTH-1:0]      a_q;
   logic [WIDTH-1:0]      mask_q;
   logic                  op_q;
   logic [TRANS_ID_W-1:0] id_q;
   logic [WIDTH-1:0]      res_q;
   logic [CNTW-1:0]       j_q;
   logic [CNTW-1:0]       k_q;
   logic [WIDTH-1:0]      res_out_q;
   logic [TRANS_ID_W-1:0] id_out_q;

   logic [WIDTH-1:0]      res_nxt;
   logic [CNTW-1:0]       k_nxt;
   logic [IDXW-1:0]       idx;
   logic                  last_chunk;
   logic                  accept;

   assign ready_o              = (state_q == IDLE);
   assign accept               = valid_i && ready_o && !flush_i;
   assign multi_cycle_o        = (state_q == DONE) && !flush_i;
   assign multi_cycle_result_o = res_out_q;
   assign trans_id_o           = id_out_q;

   // One chunk of mask positions per cycle; k carries the running count of set mask bits seen so far.
   always_comb begin
      res_nxt = res_q;
      k_nxt   = k_q;
      idx     = '0;
      for (int b = 0; b < int'(BITS_PER_CYCLE); b++) begin
         idx = j_q[IDXW-1:0] + IDXW'(b);
         if (mask_q[idx]) begin
            if (op_q) begin
               res_nxt[idx] = a_q[k_nxt[IDXW-1:0]];
            end else begin
               res_nxt[k_nxt[IDXW-1:0]] = a_q[idx];
            end
            k_nxt = k_nxt + 1'b1;
         end
      end
   end

`ifdef BITMANIP_EARLY_EXIT_EN
   assign last_chunk = (j_q == LAST_J) || ((mask_q >> (j_q + STEP)) == '0);
`else
   assign last_chunk = (j_q == LAST_J);
`endif

   // Flush beats everything; the output registers are only rewritten when a result enters DONE.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         a_q       <= '0;
         mask_q    <= '0;
         op_q      <= 1'b0;
         id_q      <= '0;
         res_q     <= '0;
         j_q       <= '0;
         k_q       <= '0;
         res_out_q <= '0;
         id_out_q  <= '0;
      end else if (flush_i) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  a_q     <= operand_a_i;
                  mask_q  <= operand_b_i;
                  op_q    <= op_bdep_i;
                  id_q    <= trans_id_i;
                  res_q   <= '0;
                  j_q     <= '0;
                  k_q     <= '0;
                  state_q <= BUSY;
`ifdef BITMANIP_EARLY_EXIT_EN
                  if (operand_b_i == '0) begin
                     res_out_q <= '0;
                     id_out_q  <= trans_id_i;
                     state_q   <= DONE;
                  end
`endif
               end
            end
            BUSY: begin
               res_q <= res_nxt;
               k_q   <= k_nxt;
               j_q   <= j_q + STEP;
               if (last_chunk) begin
                  res_out_q <= res_nxt;
                  id_out_q  <= id_q;
                  state_q   <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bitmanip_serial_unit.sv
// Randomized self-checking bench for bitmanip_serial_unit against a plain loop-based BEXT/BDEP model.
// Latency expectations follow BITMANIP_EARLY_EXIT_EN when it is defined for the build.
module tb_bitmanip_serial_unit;

   localparam int WIDTH = 64;
   localparam int BPC   = 4;
   localparam int TIDW  = 3;
   localparam int NCHK  = WIDTH / BPC;

   logic            clk_i;
   logic            rst_ni;
   logic            flush_i;
   logic            valid_i;
   logic            ready_o;
   logic            op_bdep_i;
   logic [WIDTH-1:0] operand_a_i;
   logic [WIDTH-1:0] operand_b_i;
   logic [TIDW-1:0] trans_id_i;
   logic            multi_cycle_o;
   logic [WIDTH-1:0] multi_cycle_result_o;
   logic [TIDW-1:0] trans_id_o;

   int checks = 0;
   int errors = 0;

   bitmanip_serial_unit #(
      .WIDTH(WIDTH),
      .BITS_PER_CYCLE(BPC),
      .TRANS_ID_W(TIDW)
   ) dut (
      .clk_i(clk_i),
      .rst_ni(rst_ni),
      .flush_i(flush_i),
      .valid_i(valid_i),
      .ready_o(ready_o),
      .op_bdep_i(op_bdep_i),
      .operand_a_i(operand_a_i),
      .operand_b_i(operand_b_i),
      .trans_id_i(trans_id_i),
      .multi_cycle_o(multi_cycle_o),
      .multi_cycle_result_o(multi_cycle_result_o),
      .trans_id_o(trans_id_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [63:0] refResult(input logic bdep, input logic [63:0] a, input logic [63:0] m);
      logic [63:0] r;
      int k;
      r = '0;
      k = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (m[i]) begin
            if (bdep) r[i] = a[k];
            else      r[k] = a[i];
            k++;
         end
      end
      return r;
   endfunction

   function automatic int expLatency(input logic [63:0] m);
`ifdef BITMANIP_EARLY_EXIT_EN
      int msb;
      if (m == '0) return 1;
      msb = 0;
      for (int i = 0; i < WIDTH; i++) if (m[i]) msb = i;
      return 1 + (msb + BPC) / BPC;
`else
      return NCHK + 1;
`endif
   endfunction

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic waitReady();
      int n;
      n = 0;
      while (!ready_o && n < 100) begin
         step();
         n++;
      end
      if (!ready_o) checkOutput("ready_timeout", 64'(ready_o), 64'd1);
   endtask

   task automatic driveOp(input logic bdep, input logic [63:0] a, input logic [63:0] m, input logic [TIDW-1:0] id);
      op_bdep_i   = bdep;
      operand_a_i = a;
      operand_b_i = m;
      trans_id_i  = id;
      valid_i     = 1'b1;
   endtask

   task automatic checkNoPulse(input string tag, input int n);
      int cnt;
      cnt = 0;
      repeat (n) begin
         if (multi_cycle_o) cnt++;
         step();
      end
      checkOutput(tag, 64'(cnt), 64'd0);
   endtask

   // Full single transaction: accept, wait for the pulse, compare latency/result/ID/ready and pulse width.
   task automatic applyStimulus(input string tag, input logic bdep, input logic [63:0] a, input logic [63:0] m,
                                input logic [TIDW-1:0] id);
      int lat;
      int busyReady;
      waitReady();
      driveOp(bdep, a, m, id);
      step();
      valid_i   = 1'b0;
      lat       = 1;
      busyReady = 0;
      while (!multi_cycle_o && lat < 200) begin
         if (ready_o) busyReady++;
         step();
         lat++;
      end
      checkOutput({tag, "_latency"}, 64'(lat), 64'(expLatency(m)));
      checkOutput({tag, "_result"}, multi_cycle_result_o, refResult(bdep, a, m));
      checkOutput({tag, "_id"}, 64'(trans_id_o), 64'(id));
      checkOutput({tag, "_busy_ready"}, 64'(busyReady), 64'd0);
      step();
      checkOutput({tag, "_pulse_width"}, 64'(multi_cycle_o), 64'd0);
      checkOutput({tag, "_ready_after"}, 64'(ready_o), 64'd1);
   endtask

   initial begin
      logic [63:0] a1, m1, a2, m2, ra, rm;
      logic [TIDW-1:0] id1, id2;
      logic b1, b2;
      int c, p1, busyReady, lat;

      rst_ni      = 1'b0;
      flush_i     = 1'b0;
      valid_i     = 1'b0;
      op_bdep_i   = 1'b0;
      operand_a_i = '0;
      operand_b_i = '0;
      trans_id_i  = '0;
      #13;
      checkOutput("reset_ready", 64'(ready_o), 64'd1);
      checkOutput("reset_pulse", 64'(multi_cycle_o), 64'd0);
      checkOutput("reset_result", multi_cycle_result_o, 64'd0);
      checkOutput("reset_id", 64'(trans_id_o), 64'd0);
      step();
      rst_ni = 1'b1;
      step();

      applyStimulus("bext_basic", 1'b0, 64'hF0F0, 64'hFF00, 3'd3);
      checkOutput("bext_basic_const", multi_cycle_result_o, 64'h0000_0000_0000_00F0);
      applyStimulus("bdep_basic", 1'b1, 64'hB, 64'hF0, 3'd5);
      checkOutput("bdep_basic_const", multi_cycle_result_o, 64'hB0);
      applyStimulus("bext_ones", 1'b0, 64'h0123456789ABCDEF, '1, 3'd1);
      checkOutput("bext_ones_const", multi_cycle_result_o, 64'h0123456789ABCDEF);
      applyStimulus("bdep_ones", 1'b1, 64'h0123456789ABCDEF, '1, 3'd2);
      checkOutput("bdep_ones_const", multi_cycle_result_o, 64'h0123456789ABCDEF);
      applyStimulus("zero_mask", 1'b0, 64'hDEAD_BEEF, 64'h0, 3'd4);
      applyStimulus("low_mask", 1'b0, 64'h5, 64'h0F, 3'd6);
      applyStimulus("top_bit", 1'b1, 64'h1, 64'h8000_0000_0000_0000, 3'd7);

      for (int i = 0; i < 24; i++) begin
         ra = {$urandom, $urandom};
         rm = {$urandom, $urandom};
         case ($urandom_range(3))
            0: ;
            1: rm = rm & {$urandom, $urandom};
            2: rm = rm & 64'hFFFF;
            default: rm = 64'd1 << $urandom_range(63);
         endcase
         applyStimulus("random", 1'($urandom_range(1)), ra, rm, TIDW'($urandom_range(7)));
      end

      // Back-to-back: second op held from T+1, accepted once ready returns.
      b1 = 1'b0; a1 = {$urandom, $urandom}; m1 = {$urandom, $urandom} | 64'h8000_0000_0000_0000; id1 = 3'd2;
      b2 = 1'b1; a2 = {$urandom, $urandom}; m2 = {$urandom, $urandom}; id2 = 3'd6;
      waitReady();
      driveOp(b1, a1, m1, id1);
      step();
      driveOp(b2, a2, m2, id2);
      c = 1;
      busyReady = 0;
      while (!multi_cycle_o && c < 200) begin
         if (ready_o) busyReady++;
         step();
         c++;
      end
      checkOutput("b2b_lat1", 64'(c), 64'(expLatency(m1)));
      checkOutput("b2b_res1", multi_cycle_result_o, refResult(b1, a1, m1));
      checkOutput("b2b_id1", 64'(trans_id_o), 64'(id1));
      checkOutput("b2b_busy_ready", 64'(busyReady), 64'd0);
      p1 = c;
      step();
      c++;
      checkOutput("b2b_ready_gap", 64'(ready_o), 64'd1);
      step();
      c++;
      valid_i = 1'b0;
      while (!multi_cycle_o && c < 400) begin
         step();
         c++;
      end
      checkOutput("b2b_gap", 64'(c - p1), 64'(1 + expLatency(m2)));
      checkOutput("b2b_res2", multi_cycle_result_o, refResult(b2, a2, m2));
      checkOutput("b2b_id2", 64'(trans_id_o), 64'(id2));
      step();

      // Flush while busy at T+5.
      waitReady();
      driveOp(1'b0, {$urandom, $urandom}, 64'h8000_0000_0000_00FF, 3'd1);
      step();
      valid_i = 1'b0;
      repeat (4) step();
      flush_i = 1'b1;
      #1;
      checkOutput("flush_busy_pulse", 64'(multi_cycle_o), 64'd0);
      step();
      flush_i = 1'b0;
      checkOutput("flush_busy_ready", 64'(ready_o), 64'd1);
      checkNoPulse("flush_busy_nopulse", 25);
      applyStimulus("after_flush_busy", 1'b1, 64'h0123456789ABCDEF, 64'hF0F0_0000_FFFF_000F, 3'd3);

      // Flush exactly in the DONE cycle.
      m1 = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      waitReady();
      driveOp(1'b1, {$urandom, $urandom}, m1, 3'd5);
      step();
      valid_i = 1'b0;
      lat = expLatency(m1);
      for (int i = 1; i < lat; i++) step();
      flush_i = 1'b1;
      #1;
      checkOutput("flush_done_pulse", 64'(multi_cycle_o), 64'd0);
      step();
      flush_i = 1'b0;
      checkOutput("flush_done_ready", 64'(ready_o), 64'd1);
      checkNoPulse("flush_done_nopulse", 25);
      applyStimulus("after_flush_done", 1'b0, 64'hFFFF_0000_AAAA_5555, 64'h0F0F_0F0F_0F0F_0F0F, 3'd4);

      // Asynchronous reset mid-operation at T+8.
      waitReady();
      driveOp(1'b0, {$urandom, $urandom}, 64'h8000_0000_0000_0001, 3'd7);
      step();
      valid_i = 1'b0;
      repeat (7) step();
      #2;
      rst_ni = 1'b0;
      #1;
      checkOutput("rst_mid_pulse", 64'(multi_cycle_o), 64'd0);
      checkOutput("rst_mid_result", multi_cycle_result_o, 64'd0);
      checkOutput("rst_mid_id", 64'(trans_id_o), 64'd0);
      checkOutput("rst_mid_ready", 64'(ready_o), 64'd1);
      step();
      rst_ni = 1'b1;
      step();
      checkOutput("rst_release_ready", 64'(ready_o), 64'd1);
      checkNoPulse("rst_release_nopulse", 25);
      applyStimulus("after_reset", 1'b1, 64'h3C, 64'hFF00_0000_0000_FF00, 3'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
